alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle ALU for the MIPS datapath, extending the single-cycle logic/arithmetic/shift unit with iterative MULT/MULTU/DIV/DIVU and architectural HI/LO registers. It sits in the EX stage and is driven by ALU control through a start/busy/done handshake. The pipeline stalls on `busy`, and results are registered.

## Interface
- `WIDTH`, default 32: datapath width. Must be a power of two, ≥ 8.
- `SHW`, default `$clog2(WIDTH)`: width of the shift amount.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: issue the operation on `op`/`a`/`b`/`shamt`. Sampled only when `busy`=0.
- `op` in 4: operation code (see Operation).
- `a` in WIDTH: rs operand.
- `b` in WIDTH: rt operand or sign-extended immediate.
- `shamt` in SHW: shift amount.
- `result` out WIDTH: registered result of the last single-cycle op.
- `zero` out 1: registered; 1 iff `a`−`b` == 0 for the last single-cycle op.
- `hi`, `lo` out WIDTH: HI/LO registers.
- `busy` out 1: a multiply/divide is in progress.
- `done` out 1: one-cycle pulse when the issued operation completes.

## Operation
- Single-cycle op codes:
  - AND 0000, OR 0001, ADD 0010, SLTU 0011, MFHI 0100, MFLO 0101, SUB 0110, SLT 0111 (signed), NOR 1100, SLL 1110 (`b`<<`shamt`), SRL 1111 (`b`>>`shamt`, logical).
  - ADD/SUB wrap modulo 2^WIDTH. No overflow flag.
  - SLT/SLTU produce a result of 0 or 1, zero-extended.
- Multi-cycle op codes: MULT 1000, MULTU 1001, DIV 1010, DIVU 1011.
- Unused codes: `result`=0, `zero` updated, `done` pulses. This is treated as a single-cycle op.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + `start` + single-cycle op:
  - `result` and `zero` are written.
  - `done`=1 next cycle. State stays IDLE.
- IDLE + `start` + multiply/divide:
  - Latch the operand magnitudes (signed ops take the absolute value) and the result signs.
  - Load the counter with WIDTH.
  - Go to MUL or DIV.
- MUL: one shift-add step per cycle over a 2·WIDTH product. Moves to FIX when the counter reaches 0.
- DIV: one restoring shift-subtract step per cycle. Moves to FIX when the counter reaches 0.
- FIX: apply the sign correction, write HI/LO, pulse `done`, return to IDLE.
  - MULT: `{hi,lo}` = product, negated if the operand signs differ.
  - DIV/DIVU: `lo` = quotient, `hi` = remainder.
  - Signed quotient is negated if the signs differ. Signed remainder takes the sign of `a`.
  - Signed overflow case: MIN / −1 gives `lo`=MIN, `hi`=0. This falls out of the magnitude algorithm.
- Divide by zero (`b`==0, signed or unsigned) is special-cased: `lo` = all ones, `hi` = `a`. It still takes the full latency.
- `result`/`zero` are unchanged by multiply/divide. `hi`/`lo` are unchanged by single-cycle ops.
- MFHI/MFLO read the current registered `hi`/`lo`.

## Timing
- Reset: state IDLE; `result`, `hi`, `lo` = 0; `zero`, `busy`, `done` = 0; counter = 0.
- Single-cycle op with `start` in cycle k: `result`, `zero` and `done`=1 are valid in cycle k+1.
- Multiply/divide with `start` in cycle k:
  - `busy`=1 in cycles k+1 .. k+WIDTH+1.
  - `hi`/`lo` valid and `done`=1 in cycle k+WIDTH+2, with `busy`=0.
  - Latency is WIDTH+2 (34 for WIDTH=32).
- `start` while `busy`=1 is ignored: no effect, no `done`.
- Back-to-back issue is allowed. `start` in the same cycle as `done` is accepted.
- MFHI in the `done` cycle returns the new `hi`.
- Reset asserted mid-operation aborts it. The next cycle shows the reset values and no `done`.
- Operands need to be held only in the `start` cycle.

## Structure
- Package `alu_pkg`:
  - op-code localparams (AND … DIVU);
  - FSM state enum `alu_state_t`.
- Sub-module `alu_muldiv_core`:
  - holds the iterative multiply/divide datapath, counter, MUL/DIV/FIX sequencing and sign fix-up;
  - exposes `start`/`busy`/`done`/`hi_out`/`lo_out`.
- Top level holds the combinational op mux, the `result`/`zero` registers and the HI/LO registers.

## Test plan
- ADD 0x7FFFFFFF+1 → `result`=0x80000000, `zero`=0, `done` in cycle k+1. SUB 5−5 → `result`=0, `zero`=1.
- MULT −3×7 → at cycle k+34, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy` high for exactly 33 cycles. MULTU 0xFFFFFFFF² → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0. DIVU 9/0 → `lo`=0xFFFFFFFF, `hi`=9.
- `start` with ADD during a DIV → ignored, `result` unchanged, exactly one `done`. MFLO issued in the `done` cycle → returns the new `lo`.
- `reset` pulsed at cycle k+10 of a MULT → all outputs zero, no `done`. The next MULT 2×3 completes with `lo`=6.
- SLL 1<<31=0x80000000. SRL 0x80000000>>31=1. SLT −1<1 → 1. SLTU 0xFFFFFFFF<1 → 0. Repeat with WIDTH=16: MULT −3×7 → `hi`=0xFFFF, `lo`=0xFFEB, latency 18.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state type for the
// multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_MFHI  = 4'b0100;
  localparam logic [3:0] OP_MFLO  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SLL   = 4'b1110;
  localparam logic [3:0] OP_SRL   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } alu_state_t;

  function automatic logic is_muldiv(
    input logic [3:0] op
  );
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative shift-add multiplier and restoring
// divider with sign fix-up.
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  alu_state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   dsor;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   a_raw;
  logic               neg_pq;
  logic               neg_r;
  logic               dz;
  logic               div_mode;

  logic             op_mul;
  logic             op_sgn;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign op_sgn = (op == OP_MULT) || (op == OP_DIV);
  assign sa     = op_sgn & a[WIDTH-1];
  assign sb     = op_sgn & b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;

  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    acc = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0])
      acc = acc + {1'b0, dsor};
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dsor};
    fits  = trial >= {1'b0, dsor};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (start)
          state_nxt = op_mul ? MUL : DIV;
      MUL, DIV:
        if (cnt == CW'(1))
          state_nxt = FIX;
      FIX:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      prod     <= '0;
      dsor     <= '0;
      quo      <= '0;
      rem      <= '0;
      a_raw    <= '0;
      neg_pq   <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      div_mode <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (start) begin
            cnt      <= CW'(WIDTH);
            dsor     <= mag_b;
            a_raw    <= a;
            neg_pq   <= sa ^ sb;
            neg_r    <= sa;
            div_mode <= !op_mul;
            dz       <= !op_mul && (b == '0);
            prod     <= {{WIDTH{1'b0}}, mag_a};
            quo      <= mag_a;
            rem      <= '0;
          end
        MUL: begin
          prod <= {acc, prod[WIDTH-1:1]};
          cnt  <= cnt - CW'(1);
        end
        DIV: begin
          if (fits) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_pq ? -prod : prod;
  assign quo_fix  = neg_pq ? -quo  : quo;
  assign rem_fix  = neg_r  ? -rem  : rem;

  // Divide by zero overrides the iterated result.
  always_comb begin
    if (!div_mode) begin
      hi_out = prod_fix[2*WIDTH-1:WIDTH];
      lo_out = prod_fix[WIDTH-1:0];
    end else if (dz) begin
      hi_out = a_raw;
      lo_out = '1;
    end else begin
      hi_out = rem_fix;
      lo_out = quo_fix;
    end
  end

  assign busy = state != IDLE;
  assign done = state == FIX;

endmodule

// File: rtl/alu_seq.sv
// EX-stage ALU: single-cycle op mux with result/zero
// and HI/LO registers around the mul/div core.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  logic             md_go;
  logic             sc_go;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] res_nxt;

  assign md_go = start && !busy && is_muldiv(op);
  assign sc_go = start && !busy && !is_muldiv(op);

  alu_muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (md_go),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (md_done),
    .hi_out (md_hi),
    .lo_out (md_lo)
  );

  always_comb begin
    res_nxt = '0;
    unique case (op)
      OP_AND:  res_nxt = a & b;
      OP_OR:   res_nxt = a | b;
      OP_ADD:  res_nxt = a + b;
      OP_SUB:  res_nxt = a - b;
      OP_SLTU: res_nxt = WIDTH'(a < b);
      OP_SLT:  res_nxt = WIDTH'($signed(a) < $signed(b));
      OP_MFHI: res_nxt = hi;
      OP_MFLO: res_nxt = lo;
      OP_NOR:  res_nxt = ~(a | b);
      OP_SLL:  res_nxt = b << shamt;
      OP_SRL:  res_nxt = b >> shamt;
      default: res_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sc_go) begin
        result <= res_nxt;
        zero   <= a == b;
        done   <= 1'b1;
      end
      if (md_done) begin
        hi   <= md_hi;
        lo   <= md_lo;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at
// WIDTH=32 and WIDTH=16.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result, hi, lo;
  logic        zero, busy, done;

  logic        start16 = 1'b0;
  logic [3:0]  op16 = 4'd0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic [3:0]  sh16 = '0;
  logic [15:0] result16, hi16, lo16;
  logic        zero16, busy16, done16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start),
    .op(op), .a(a), .b(b), .shamt(shamt),
    .result(result), .zero(zero), .hi(hi),
    .lo(lo), .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(start16),
    .op(op16), .a(a16), .b(b16), .shamt(sh16),
    .result(result16), .zero(zero16), .hi(hi16),
    .lo(lo16), .busy(busy16), .done(done16)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic sc(input string tag,
                    input logic [3:0] o,
                    input logic [31:0] va,
                    input logic [31:0] vb,
                    input logic [4:0] sh,
                    input logic [31:0] er,
                    input logic ez);
    @(negedge clk);
    op = o; a = va; b = vb; shamt = sh;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_res"}, 64'(result), 64'(er));
    chk({tag, "_zero"}, 64'(zero), 64'(ez));
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic md(input string tag,
                    input logic [3:0] o,
                    input logic [31:0] va,
                    input logic [31:0] vb,
                    input logic [31:0] eh,
                    input logic [31:0] el);
    int lat;
    int nb;
    @(negedge clk);
    op = o; a = va; b = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = '0; b = '0;
    lat = 1; nb = 0;
    while (!done && lat < 200) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd34);
    chk({tag, "_busycyc"}, 64'(nb), 64'd33);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int lat;
    int nd;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", {61'd0, zero, busy, done}, 64'd0);

    sc("add", OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0,
       32'h8000_0000, 1'b0);
    sc("sub", OP_SUB, 32'd5, 32'd5, 5'd0,
       32'h0, 1'b1);
    sc("sll", OP_SLL, 32'd0, 32'd1, 5'd31,
       32'h8000_0000, 1'b0);
    sc("srl", OP_SRL, 32'd0, 32'h8000_0000, 5'd31,
       32'h1, 1'b0);
    sc("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0,
       32'h1, 1'b0);
    sc("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0,
       32'h0, 1'b0);
    sc("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_00FF,
       5'd0, 32'h00F0_0034, 1'b0);
    sc("or", OP_OR, 32'hF0F0_1234, 32'h0FF0_00FF,
       5'd0, 32'hFFF0_12FF, 1'b0);
    sc("nor", OP_NOR, 32'hF0F0_1234, 32'h0FF0_00FF,
       5'd0, 32'h000F_ED00, 1'b0);
    sc("unused", 4'b1101, 32'd3, 32'd3, 5'd0,
       32'h0, 1'b1);

    md("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7,
       32'hFFFF_FFFF, 32'hFFFF_FFEB);
    chk("mult_keeps_res", 64'(result), 64'd0);
    md("multu", OP_MULTU, 32'hFFFF_FFFF,
       32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    md("div", OP_DIV, 32'hFFFF_FFF9, 32'd2,
       32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md("divovf", OP_DIV, 32'h8000_0000,
       32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    md("divz", OP_DIVU, 32'd9, 32'd0,
       32'd9, 32'hFFFF_FFFF);
    sc("mfhi", OP_MFHI, 32'd1, 32'd2, 5'd0,
       32'd9, 1'b0);
    sc("mflo", OP_MFLO, 32'd4, 32'd4, 5'd0,
       32'hFFFF_FFFF, 1'b1);
    chk("sc_keeps_hi", 64'(hi), 64'd9);

    // ADD issued mid-divide must be dropped
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nd = 0;
    while (!done && lat < 200) begin
      start = (lat == 5);
      if (lat == 5) begin
        op = OP_ADD; a = 32'd1; b = 32'd1;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("ign_lat", 64'(lat), 64'd34);
    chk("ign_res", 64'(result), 64'hFFFF_FFFF);
    chk("ign_lo", 64'(lo), 64'd14);
    chk("ign_hi", 64'(hi), 64'd2);
    op = OP_MFLO; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_mflo", 64'(result), 64'd14);
    chk("b2b_done", 64'(done), 64'd1);

    // reset at cycle k+10 of a MULT
    @(negedge clk);
    op = OP_MULT; a = 32'd5; b = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_res", 64'(result), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_flags", {61'd0, zero, busy, done},
        64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", 64'(nd), 64'd0);
    md("mult23", OP_MULT, 32'd2, 32'd3, 32'd0,
       32'd6);

    // 16-bit instance
    @(negedge clk);
    op16 = OP_MULT; a16 = 16'hFFFD; b16 = 16'd7;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("m16_lat", 64'(lat), 64'd18);
    chk("m16_hi", 64'(hi16), 64'hFFFF);
    chk("m16_lo", 64'(lo16), 64'hFFEB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
